// File: rtl/iccm_readback.sv
// Streams a range of ICCM words to the UART TX byte port, LSB first, one read per word.
// Start to first byte is 3 cycles; holds each byte until tx_ready_i and stalls the read stream meanwhile.
module iccm_readback #(
  parameter int          ADDR_W      = 14,
  parameter int          CNT_W       = 15,
  parameter bit          STOP_ON_END = 1'b1,
  parameter logic [31:0] END_WORD    = 32'h00000fff
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  input  logic              abort_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [31:0]       rdata_i,
  output logic [7:0]        tx_byte_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  words_sent_o
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_q, word_d;
  logic [CNT_W-1:0]    words_sent_q, words_sent_d;
  logic                tx_hs;
  logic                last_word;
  logic [7:0]          byte_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign tx_hs     = (state_q == SEND) && tx_ready_i;
  assign last_word = (remaining_q == CNT_W'(1)) || (STOP_ON_END && (word_q == END_WORD));

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    words_sent_d = words_sent_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (word_count_i != '0) begin
            cur_addr_d   = base_addr_i;
            remaining_d  = word_count_i;
            words_sent_d = '0;
            state_d      = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: state_d = abort_i ? IDLE : WAIT;
      WAIT: begin
        word_d     = rdata_i;
        byte_idx_d = '0;
        state_d    = abort_i ? IDLE : SEND;
      end
      SEND: begin
        // A byte accepted in the abort cycle is still accounted for.
        if (tx_hs) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            words_sent_d = words_sent_q + CNT_W'(1);
            cur_addr_d   = cur_addr_q + ADDR_W'(1);
            remaining_d  = remaining_q - CNT_W'(1);
            state_d      = last_word ? DONE : READ;
          end
        end
        if (abort_i) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (byte_idx_q)
      2'd0:    byte_sel = word_q[7:0];
      2'd1:    byte_sel = word_q[15:8];
      2'd2:    byte_sel = word_q[23:16];
      default: byte_sel = word_q[31:24];
    endcase
  end

  always_comb begin
    busy_o       = (state_q != IDLE);
    req_o        = (state_q == READ);
    addr_o       = (state_q == READ) ? cur_addr_q : '0;
    tx_valid_o   = (state_q == SEND);
    tx_byte_o    = (state_q == SEND) ? byte_sel : 8'h00;
    done_o       = (state_q == DONE);
    words_sent_o = words_sent_q;
  end

endmodule

// File: doc/iccm_readback.md
Name: iccm_readback

Overview:
Reads a contiguous range of ICCM words and streams them out byte by byte to the UART transmitter. Bytes are sent least-significant first, which is the same byte order the ICCM loader uses to assemble them. Used for host-side verification of a downloaded program. Sits between the ICCM read port and the UART TX byte interface, alongside the loader.

Parameters:
ADDR_W, 14, ICCM word-address width.
CNT_W, 15, width of the word-count input and counters (covers 2^ADDR_W words).
STOP_ON_END, 1, when 1, stop after sending a word equal to END_WORD.
END_WORD, 32'h00000fff, end-of-program marker word.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  one-cycle pulse; begin a readback. Ignored while busy_o=1.
base_addr_i  in  ADDR_W  first word address; sampled with start_i.
word_count_i  in  CNT_W  number of words to send; sampled with start_i.
abort_i  in  1  terminate the current readback.
req_o  out  1  ICCM read strobe, one cycle per word.
addr_o  out  ADDR_W  ICCM word address; valid while req_o=1.
rdata_i  in  32  ICCM read data; valid exactly 1 cycle after req_o.
tx_byte_o  out  8  byte to transmit.
tx_valid_o  out  1  tx_byte_o valid.
tx_ready_i  in  1  UART TX accepts the byte; transfer occurs when tx_valid_o && tx_ready_i.
busy_o  out  1  readback in progress.
done_o  out  1  one-cycle pulse on normal completion.
words_sent_o  out  CNT_W  words fully transmitted in the current or last run.

Behaviour:
- Reset (rst_i=1 at a clock edge): FSM goes to IDLE. All outputs 0: req_o, addr_o, tx_byte_o, tx_valid_o, busy_o, done_o, words_sent_o. Internal address, remaining-count, byte index and word register also clear to 0. Reset mid-transfer abandons the partial word with no further tx_valid_o.
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE (busy_o=0):
  - start_i=1 with word_count_i!=0: latch base_addr_i into cur_addr and word_count_i into remaining; clear words_sent_o; go to READ.
  - start_i=1 with word_count_i==0: go to DONE. No ICCM read and no tx byte occur.
- READ: req_o=1 and addr_o=cur_addr for exactly one cycle, then go to WAIT.
- WAIT: capture rdata_i into word_q; set byte_idx=0; go to SEND.
- SEND: tx_valid_o=1 and tx_byte_o=word_q[8*byte_idx +: 8]. Byte order is [7:0], [15:8], [23:16], [31:24].
  - tx_valid_o and tx_byte_o hold stable until the handshake.
  - On handshake with byte_idx<3: byte_idx increments; stay in SEND.
  - On handshake with byte_idx==3: words_sent_o increments; cur_addr increments, wrapping modulo 2^ADDR_W; remaining decrements.
    - Go to DONE if the old remaining==1, or if STOP_ON_END=1 and word_q==END_WORD.
    - Otherwise go to READ.
- DONE: done_o=1 for one cycle, then go to IDLE. busy_o=1 in READ, WAIT, SEND and DONE.
- abort_i=1 in READ, WAIT or SEND: go to IDLE next cycle.
  - tx_valid_o and req_o drop to 0 on that edge; a partial word is dropped.
  - done_o is not pulsed; words_sent_o keeps its value.
  - A handshake in the same cycle as abort still counts (the byte is consumed), but no further bytes are sent.
- abort_i in IDLE or DONE: no effect.
- Latency: start_i at cycle T gives req_o at T+1 and first tx_valid_o at T+3. With tx_ready_i tied high, each word takes 6 cycles (READ, WAIT, 4×SEND). The last byte handshake at cycle N gives done_o at N+1.
- start_i while busy_o=1: ignored entirely; latched inputs are unchanged.
- STOP_ON_END check uses the captured word_q. The END_WORD itself is transmitted in full before stopping.

Test Plan:
- Reset then idle: apply rst_i; hold start_i=0 for 20 cycles -> all outputs 0, no req_o.
- Basic run, tx_ready_i=1: base=0x0010, count=2, ICCM[0x10]=0x11223344, ICCM[0x11]=0xAABBCCDD -> req_o at addr 0x10 then 0x11. tx byte sequence 44,33,22,11,DD,CC,BB,AA. done_o 1 cycle after byte AA; words_sent_o=2; start to done = 13 cycles.
- Backpressure: same run with tx_ready_i random ~30% -> identical byte sequence; tx_byte_o never changes while tx_valid_o=1 && tx_ready_i=0.
- End marker and wrap: base=0x3FFF, count=5, ICCM[0x3FFF]=0x01020304, ICCM[0x0000]=0x00000fff -> reads 0x3FFF then 0x0000. Bytes 04,03,02,01,FF,0F,00,00 are sent, then done_o; words_sent_o=2.
- Zero count and busy start: start with count=0 -> done_o at T+1, no req_o or tx_valid_o. During a 3-word run, pulse start_i with a different base -> ignored; the original range completes.
- Abort: during a 4-word run, abort_i after byte 2 of word 1 -> next cycle busy_o=0 and tx_valid_o=0, no done_o, words_sent_o=1. A following start runs normally.
